// File: rtl/freq_meter_pkg.sv
// -----------------------------------------------------------------------------
// freq_meter_pkg
// Shared types and constants for the frequency meter datapath.
//   byte_t         : one UART byte
//   framer_state_t : packet framer FSM states (CSUM is only reachable when
//                    PACKET_FRAMER_CHECKSUM_EN is defined)
//   PKT_HEADER     : default first byte of every framed packet
//   csum8()        : 8-bit wrapping sum of the three packet bytes
// -----------------------------------------------------------------------------
package freq_meter_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    HI   = 3'd2,
    LO   = 3'd3,
    CSUM = 3'd4
  } framer_state_t;

  localparam byte_t PKT_HEADER = 8'hA5;

  // Carries out of bit 7 are dropped on purpose: the checksum is mod 256.
  function automatic byte_t csum8(input byte_t hdr, input byte_t hi, input byte_t lo);
    return hdr + hi + lo;
  endfunction

endpackage

// File: rtl/packet_framer.sv
// -----------------------------------------------------------------------------
// packet_framer
// Frames a 16-bit edge count into a byte packet (HEADER, count[15:8],
// count[7:0] and, optionally, a checksum) and streams it to a UART
// transmitter over a valid/ready handshake. A single pending slot holds a
// request that arrives while a packet is still in flight.
//
// Optional feature macro: PACKET_FRAMER_CHECKSUM_EN
//   defined   -> 4-byte packets, last byte is the 8-bit wrapping checksum
//   undefined -> 3-byte packets, LO is the last byte
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   counter_in   edge count from the counter stage
//   send_packet  single-cycle request to frame counter_in
//   tx_data      byte presented to the UART transmitter (registered)
//   tx_valid     tx_data is valid (registered)
//   tx_ready     transmitter accepts the byte this cycle
//   busy         packet in flight (state != IDLE), registered
//   overrun      one-cycle pulse: a pending request was overwritten
// -----------------------------------------------------------------------------
module packet_framer
  import freq_meter_pkg::*;
#(
  parameter byte_t HEADER = PKT_HEADER,
  parameter int    CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] counter_in,
  input  logic             send_packet,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             overrun
);

`ifdef PACKET_FRAMER_CHECKSUM_EN
  localparam framer_state_t LAST_STATE = CSUM;
`else
  localparam framer_state_t LAST_STATE = LO;
`endif

  framer_state_t    state_q, state_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             pending_valid_q, pending_valid_d;
  byte_t            tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;

  logic xfer;
  logic last_xfer;
  logic load;
  logic take_pending;
  logic bypass;

  assign xfer      = tx_valid_q && tx_ready;
  assign last_xfer = xfer && (state_q == LAST_STATE);
  // A new packet may start either from IDLE or in the very cycle the last
  // byte of the previous packet leaves, which gives zero-gap back-to-back.
  assign load      = (state_q == IDLE) || last_xfer;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      active_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      tx_data_q       <= '0;
      tx_valid_q      <= 1'b0;
      busy_q          <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      active_q        <= active_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      tx_data_q       <= tx_data_d;
      tx_valid_q      <= tx_valid_d;
      busy_q          <= busy_d;
      overrun_q       <= overrun_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: FSM, active capture and pending slot
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    active_d        = active_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    overrun_d       = 1'b0;
    take_pending    = 1'b0;
    bypass          = 1'b0;

    if (load) begin
      if (pending_valid_q) begin
        active_d        = pending_q;
        pending_valid_d = 1'b0;
        take_pending    = 1'b1;
        state_d         = HDR;
      end else if (send_packet) begin
        active_d = counter_in;
        bypass   = 1'b1;
        state_d  = HDR;
      end else begin
        state_d = IDLE;
      end
    end else if (xfer) begin
      case (state_q)
        HDR:     state_d = HI;
        HI:      state_d = LO;
`ifdef PACKET_FRAMER_CHECKSUM_EN
        LO:      state_d = CSUM;
`endif
        default: state_d = state_q;
      endcase
    end

    // A request that did not go straight into active lands in the pending
    // slot. If the slot still holds an unconsumed request it is overwritten
    // and flagged; a slot drained this very cycle is free, so no overrun.
    if (send_packet && !bypass) begin
      overrun_d       = pending_valid_q && !take_pending;
      pending_d       = counter_in;
      pending_valid_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: registered from next state so tx_data/tx_valid are glitch
  // free and hold steady while the transmitter stalls.
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_valid_d = (state_d != IDLE);
    busy_d     = (state_d != IDLE);
    case (state_d)
      HDR:     tx_data_d = HEADER;
      HI:      tx_data_d = active_d[CNT_W-1 -: 8];
      LO:      tx_data_d = active_d[7:0];
`ifdef PACKET_FRAMER_CHECKSUM_EN
      CSUM:    tx_data_d = csum8(HEADER, active_d[CNT_W-1 -: 8], active_d[7:0]);
`endif
      default: tx_data_d = '0;
    endcase
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule
